// File: rtl/gemm_ctrl.sv
// GEMM sequencer: walks (i, j, k), issues row-major A/B/C read addresses, drives the
// MAC enable/clear strobes through a RD_LAT-deep delay line and writes each result.
// Optional build macro GEMM_CTRL_PERF_CNT_EN adds a saturating 32-bit busy-cycle counter.
module gemm_ctrl #(
    parameter int unsigned MATRIX_HEIGHT = 4,
    parameter int unsigned MATRIX_WIDTH  = 4,
    parameter int unsigned MATRIX_ADJUST = 4,
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned MAC_LAT       = 2,
    localparam int unsigned AW_A = (MATRIX_HEIGHT * MATRIX_ADJUST > 1) ?
                                   $clog2(MATRIX_HEIGHT * MATRIX_ADJUST) : 1,
    localparam int unsigned AW_B = (MATRIX_ADJUST * MATRIX_WIDTH > 1) ?
                                   $clog2(MATRIX_ADJUST * MATRIX_WIDTH) : 1,
    localparam int unsigned AW_C = (MATRIX_HEIGHT * MATRIX_WIDTH > 1) ?
                                   $clog2(MATRIX_HEIGHT * MATRIX_WIDTH) : 1
) (
    input  logic            iclk,
    input  logic            irst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            mem_rd_en,
    output logic [AW_A-1:0] a_addr,
    output logic [AW_B-1:0] b_addr,
    output logic            c_rd_en,
    output logic [AW_C-1:0] c_addr,
    output logic            mac_en,
    output logic            mac_clr,
`ifdef GEMM_CTRL_PERF_CNT_EN
    output logic [31:0]     cycle_cnt,
`endif
    output logic            out_we,
    output logic [AW_C-1:0] out_addr
);

    localparam int unsigned M    = MATRIX_HEIGHT;
    localparam int unsigned N    = MATRIX_WIDTH;
    localparam int unsigned K    = MATRIX_ADJUST;
    localparam int unsigned DLEN = RD_LAT + MAC_LAT;
    localparam int unsigned IW   = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW   = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned DW   = (DLEN > 1) ? $clog2(DLEN) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [JW-1:0]       j_q, j_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DW-1:0]       drn_q, drn_d;
    logic [RD_LAT-1:0]   en_dly_q;
    logic [RD_LAT-1:0]   clr_dly_q;
    logic                kill;

    // Abort only matters once a GEMM is running; in IDLE it simply blocks start.
    assign kill = abort && (state_q != StIdle);

    // State and index registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
        end
    end

    // Next-state and index stepping.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        drn_d   = drn_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StIssue;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            StIssue: begin
                if (k_q == KW'(K - 1)) begin
                    state_d = StDrain;
                    k_d     = '0;
                    drn_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                if (drn_q == DW'(DLEN - 1)) begin
                    state_d = StWrite;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            StWrite: begin
                k_d = '0;
                if (i_q == IW'(M - 1) && j_q == JW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                    if (j_q == JW'(N - 1)) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                i_d     = '0;
                j_d     = '0;
            end
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            drn_d   = '0;
        end
    end

    // Read-to-MAC delay line; flushed on abort so nothing reaches the accumulator.
    always_ff @(posedge iclk) begin
        if (irst || kill) begin
            en_dly_q  <= '0;
            clr_dly_q <= '0;
        end else begin
            en_dly_q[0]  <= mem_rd_en;
            clr_dly_q[0] <= c_rd_en;
            for (int n = 1; n < int'(RD_LAT); n++) begin
                en_dly_q[n]  <= en_dly_q[n-1];
                clr_dly_q[n] <= clr_dly_q[n-1];
            end
        end
    end

    // Outputs decoded from state; addresses forced to 0 while their strobe is low.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_rd_en = (state_q == StIssue);
        c_rd_en   = mem_rd_en && (k_q == '0);
        out_we    = (state_q == StWrite);
        mac_en    = en_dly_q[RD_LAT-1];
        mac_clr   = clr_dly_q[RD_LAT-1];
        a_addr    = '0;
        b_addr    = '0;
        c_addr    = '0;
        out_addr  = '0;
        if (mem_rd_en) begin
            a_addr = AW_A'(32'(i_q) * K + 32'(k_q));
            b_addr = AW_B'(32'(k_q) * N + 32'(j_q));
        end
        if (c_rd_en) begin
            c_addr = AW_C'(32'(i_q) * N + 32'(j_q));
        end
        if (out_we) begin
            out_addr = AW_C'(32'(i_q) * N + 32'(j_q));
        end
    end

`ifdef GEMM_CTRL_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Busy-cycle counter: cleared on accepted start, saturates, holds when idle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_q <= '0;
        end else if (state_q == StIdle && start && !abort) begin
            cnt_q <= '0;
        end else if (busy && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule
